// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IF/MEM requester handshakes, stall flags and the byte-wide RAM port.
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_width;
  logic              mem_sext;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              stall_if;
  logic              stall_mem;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  // Requesters and RAM model side.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_width, mem_sext, mem_wdata, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, stall_if, stall_mem, ram_addr, ram_wr, ram_dout
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_width, mem_sext, mem_wdata, ram_din,
    output if_data, if_done, mem_rdata, mem_done, stall_if, stall_mem, ram_addr, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one synchronous RAM port between IF fetches and MEM loads/stores.
// Optional one-entry fetch buffer enabled by defining FETCH_BUF_EN.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD_IF, RD_MEM, WR_MEM, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [3:0]  cnt_inc;
  logic [3:0]  nbytes;
  logic [31:0] asm_q, asm_nxt, ld_ext;
  logic [1:0]  cap_idx;
  logic [7:0]  wbyte;
  logic        gnt_mem;
  logic        rd, rd_issue, rd_cap, rd_last, wr_more;
  logic        fb_hit;
  logic [31:0] fb_data;

  assign bus.stall_if  = bus.if_req  && !bus.if_done;
  assign bus.stall_mem = bus.mem_req && !bus.mem_done;

  // Byte count of the access in flight; IF is always a full word.
  always_comb begin
    nbytes = 4'd4;
    if (gnt_mem) begin
      case (bus.mem_width)
        2'b00:   nbytes = 4'd1;
        2'b01:   nbytes = 4'd2;
        default: nbytes = 4'd4;
      endcase
    end
  end

`ifdef FETCH_BUF_EN
  logic              fb_vld;
  logic [ADDR_W-1:0] fb_addr;
  logic [31:0]       fb_q;

  assign fb_hit  = fb_vld && (bus.if_addr == fb_addr);
  assign fb_data = fb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_vld  <= 1'b0;
      fb_addr <= '0;
      fb_q    <= '0;
    end else if (state == IDLE && bus.mem_req && bus.mem_we) begin
      fb_vld <= 1'b0;
    end else if (state == RD_IF && rd_last) begin
      fb_vld  <= 1'b1;
      fb_addr <= bus.if_addr;
      fb_q    <= asm_nxt;
    end
  end
`else
  assign fb_hit  = 1'b0;
  assign fb_data = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.mem_req)     state_nxt = bus.mem_we ? WR_MEM : RD_MEM;
        else if (bus.if_req) state_nxt = fb_hit ? DONE : RD_IF;
      end
      RD_IF, RD_MEM: if (rd_last) state_nxt = DONE;
      WR_MEM:        if (!wr_more) state_nxt = DONE;
      DONE:          state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  // cnt = cycles spent in the access state; reads capture RAM_LAT cycles behind the address.
  always_comb begin
    cnt_inc  = {1'b0, cnt} + 4'd1;
    rd       = (state == RD_IF) || (state == RD_MEM);
    rd_issue = rd && (cnt_inc < nbytes);
    rd_cap   = rd && (cnt >= 3'(RAM_LAT));
    rd_last  = rd && ({1'b0, cnt} == nbytes);
    wr_more  = (state == WR_MEM) && (cnt_inc < nbytes);
    cap_idx  = cnt[1:0] - 2'd1;
    wbyte    = bus.mem_wdata[8*cnt_inc[1:0] +: 8];
    asm_nxt  = asm_q;
    asm_nxt[8*cap_idx +: 8] = bus.ram_din;
    case (bus.mem_width)
      2'b00:   ld_ext = {{24{bus.mem_sext & asm_nxt[7]}},  asm_nxt[7:0]};
      2'b01:   ld_ext = {{16{bus.mem_sext & asm_nxt[15]}}, asm_nxt[15:0]};
      default: ld_ext = asm_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      asm_q         <= '0;
      gnt_mem       <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wr    <= 1'b0;
      bus.ram_dout  <= '0;
      bus.if_data   <= '0;
      bus.if_done   <= 1'b0;
      bus.mem_rdata <= '0;
      bus.mem_done  <= 1'b0;
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      bus.ram_wr   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.mem_req) begin
            gnt_mem      <= 1'b1;
            bus.ram_addr <= bus.mem_addr;
            if (bus.mem_we) begin
              bus.ram_wr   <= 1'b1;
              bus.ram_dout <= bus.mem_wdata[7:0];
            end
          end else if (bus.if_req) begin
            gnt_mem <= 1'b0;
            if (fb_hit) begin
              bus.if_data <= fb_data;
              bus.if_done <= 1'b1;
            end else begin
              bus.ram_addr <= bus.if_addr;
            end
          end
        end
        RD_IF, RD_MEM: begin
          cnt <= cnt + 3'd1;
          if (rd_issue) bus.ram_addr <= bus.ram_addr + ADDR_W'(1);
          if (rd_cap)   asm_q <= asm_nxt;
          if (rd_last) begin
            if (state == RD_IF) begin
              bus.if_data <= asm_nxt;
              bus.if_done <= 1'b1;
            end else begin
              bus.mem_rdata <= ld_ext;
              bus.mem_done  <= 1'b1;
            end
          end
        end
        WR_MEM: begin
          cnt <= cnt + 3'd1;
          if (wr_more) begin
            bus.ram_addr <= bus.ram_addr + ADDR_W'(1);
            bus.ram_wr   <= 1'b1;
            bus.ram_dout <= wbyte;
          end else begin
            bus.mem_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected timed events, a negedge monitor checks them.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus();
  mem_arbiter #(.ADDR_W(32), .RAM_LAT(1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

`ifdef FETCH_BUF_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    bus.ram_din <= ram[bus.ram_addr[11:0]];
    if (bus.ram_wr) ram[bus.ram_addr[11:0]] = bus.ram_dout;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] val; bit chk; } ev_t;
  typedef struct { int cyc; logic [31:0] addr; logic [7:0] dat; } wr_t;
  ev_t if_q[$], mem_q[$], addr_q[$], stall_q[$];
  wr_t wr_q[$];
  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  ev_t e;
  wr_t w;
  always @(negedge clk) begin
    while (addr_q.size() > 0 && addr_q[0].cyc <= cyc) begin
      e = addr_q.pop_front();
      check("ram_addr", bus.ram_addr, e.val);
    end
    while (stall_q.size() > 0 && stall_q[0].cyc <= cyc) begin
      e = stall_q.pop_front();
      check("stall_if", 32'(bus.stall_if), e.val);
    end
    if (bus.if_done) begin
      if (if_q.size() == 0) fail("unexpected if_done");
      else begin
        e = if_q.pop_front();
        check("if_done_cycle", cyc, e.cyc);
        check("if_data", bus.if_data, e.val);
      end
    end
    if (bus.mem_done) begin
      if (mem_q.size() == 0) fail("unexpected mem_done");
      else begin
        e = mem_q.pop_front();
        check("mem_done_cycle", cyc, e.cyc);
        if (e.chk) check("mem_rdata", bus.mem_rdata, e.val);
      end
    end
    if (bus.ram_wr) begin
      if (wr_q.size() == 0) fail("unexpected ram_wr");
      else begin
        w = wr_q.pop_front();
        check("ram_wr_cycle", cyc, w.cyc);
        check("ram_wr_addr", bus.ram_addr, w.addr);
        check("ram_dout", 32'(bus.ram_dout), 32'(w.dat));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_mem);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = is_mem ? bus.mem_done : bus.if_done;
    end
    if (!seen) fail(is_mem ? "timeout mem_done" : "timeout if_done");
  endtask

  // hit: fetch expected to be served from the fetch buffer; ram_addr then holds at hold_addr.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input bit hit,
                       input logic [31:0] hold_addr);
    int t0;
    step();
    t0 = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    if (hit) begin
      addr_q.push_back('{t0 + 1, hold_addr, 1'b1});
      stall_q.push_back('{t0, 32'd1, 1'b1});
      stall_q.push_back('{t0 + 1, 32'd0, 1'b1});
      if_q.push_back('{t0 + 1, exp, 1'b1});
    end else begin
      for (int k = 0; k < 4; k++) addr_q.push_back('{t0 + 1 + k, addr + 32'(k), 1'b1});
      for (int k = 0; k < 6; k++) stall_q.push_back('{t0 + k, 32'd1, 1'b1});
      stall_q.push_back('{t0 + 6, 32'd0, 1'b1});
      if_q.push_back('{t0 + 6, exp, 1'b1});
    end
    wait_done(1'b0);
    step();
    bus.if_req = 1'b0;
  endtask

  task automatic mem_op(input bit we, input logic [31:0] addr, input logic [1:0] width,
                        input bit sext, input logic [31:0] wdata, input logic [31:0] exp);
    int t0, n;
    n = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
    step();
    t0 = cyc;
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_width = width;
    bus.mem_sext  = sext;
    bus.mem_wdata = wdata;
    if (we) begin
      for (int k = 0; k < n; k++) wr_q.push_back('{t0 + 1 + k, addr + 32'(k), wdata[8*k +: 8]});
      mem_q.push_back('{t0 + n + 1, 32'd0, 1'b0});
    end else begin
      for (int k = 0; k < n; k++) addr_q.push_back('{t0 + 1 + k, addr + 32'(k), 1'b1});
      mem_q.push_back('{t0 + n + 2, exp, 1'b1});
    end
    wait_done(1'b1);
    step();
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h020] = 8'h80;
    ram[12'h030] = 8'h34; ram[12'h031] = 8'h92;
    ram[12'h042] = 8'h5A;
    ram[12'h080] = 8'h01; ram[12'h081] = 8'h02; ram[12'h082] = 8'h03; ram[12'h083] = 8'h04;
    ram[12'h200] = 8'hAA; ram[12'h201] = 8'hBB; ram[12'h202] = 8'hCC; ram[12'h203] = 8'hDD;
    ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;
    ram[12'h104] = 8'h99; ram[12'h105] = 8'h88; ram[12'h106] = 8'h77; ram[12'h107] = 8'h66;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0;
    bus.mem_width = 2'b00; bus.mem_sext = 1'b0; bus.mem_wdata = '0;

    #2 reset_n = 1'b0;
    #20;
    check("reset ram_addr", bus.ram_addr, 32'h0);
    check("reset ram_wr", 32'(bus.ram_wr), 32'h0);
    check("reset if_done", 32'(bus.if_done), 32'h0);
    check("reset mem_done", 32'(bus.mem_done), 32'h0);
    check("reset if_data", bus.if_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    fetch(32'h100, 32'h0000_0513, 1'b0, 32'h0);

    mem_op(1'b0, 32'h20, 2'b00, 1'b1, 32'h0, 32'hFFFF_FF80);
    mem_op(1'b0, 32'h20, 2'b00, 1'b0, 32'h0, 32'h0000_0080);
    mem_op(1'b0, 32'h30, 2'b01, 1'b1, 32'h0, 32'hFFFF_9234);

    mem_op(1'b1, 32'h40, 2'b01, 1'b0, 32'hDEAD_BEEF, 32'h0);
    check("ram[0x40]", 32'(ram[12'h040]), 32'hEF);
    check("ram[0x41]", 32'(ram[12'h041]), 32'hBE);
    check("ram[0x42] untouched", 32'(ram[12'h042]), 32'h5A);

    // IF and MEM together: MEM word load first, IF granted in the IDLE cycle after mem_done.
    step();
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h80; bus.mem_width = 2'b10; bus.mem_sext = 1'b0;
    for (int k = 0; k < 4; k++) addr_q.push_back('{t0 + 1 + k, 32'h80 + 32'(k), 1'b1});
    addr_q.push_back('{t0 + 7, 32'h83, 1'b1});
    for (int k = 0; k < 4; k++) addr_q.push_back('{t0 + 8 + k, 32'h200 + 32'(k), 1'b1});
    for (int k = 0; k < 13; k++) stall_q.push_back('{t0 + k, 32'd1, 1'b1});
    stall_q.push_back('{t0 + 13, 32'd0, 1'b1});
    mem_q.push_back('{t0 + 6, 32'h0403_0201, 1'b1});
    if_q.push_back('{t0 + 13, 32'hDDCC_BBAA, 1'b1});
    wait_done(1'b1);
    step();
    bus.mem_req = 1'b0;
    wait_done(1'b0);
    step();
    bus.if_req = 1'b0;

    mem_op(1'b0, 32'hFFFF_FFFE, 2'b10, 1'b0, 32'h0, 32'h4433_2211);

    // Reset in cycle 3 of a fetch aborts it with no done pulse.
    step();
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    addr_q.push_back('{t0 + 1, 32'h104, 1'b1});
    addr_q.push_back('{t0 + 2, 32'h105, 1'b1});
    for (int k = 0; k < 3; k++) stall_q.push_back('{t0 + k, 32'd1, 1'b1});
    step(); step(); step();
    reset_n = 1'b0;
    #1;
    check("abort ram_addr", bus.ram_addr, 32'h0);
    check("abort if_done", 32'(bus.if_done), 32'h0);
    check("abort if_data", bus.if_data, 32'h0);
    check("abort mem_rdata", bus.mem_rdata, 32'h0);
    check("abort ram_dout", 32'(bus.ram_dout), 32'h0);
    bus.if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    fetch(32'h100, 32'h0000_0513, 1'b0, 32'h0);
    fetch(32'h100, 32'h0000_0513, FB, 32'h103);
    mem_op(1'b1, 32'h300, 2'b00, 1'b0, 32'h0000_0077, 32'h0);
    check("ram[0x300]", 32'(ram[12'h300]), 32'h77);
    fetch(32'h100, 32'h0000_0513, 1'b0, 32'h0);

    repeat (3) step();
    while (if_q.size() > 0)    begin void'(if_q.pop_front());    fail("missing if_done"); end
    while (mem_q.size() > 0)   begin void'(mem_q.pop_front());   fail("missing mem_done"); end
    while (wr_q.size() > 0)    begin void'(wr_q.pop_front());    fail("missing ram_wr"); end
    while (addr_q.size() > 0)  begin void'(addr_q.pop_front());  fail("unchecked ram_addr"); end
    while (stall_q.size() > 0) begin void'(stall_q.pop_front()); fail("unchecked stall_if"); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
